// File: rtl/slice_renderer.sv
// Column renderer: takes one wall slice per column from a slice source and plots V_RES pixels per column.
// Pixels appear one cycle after their DRAW cycle; FETCH stalls until the source is valid, and plot has no backpressure.
module slice_renderer #(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int CW        = 3,
  parameter int FRAME_DIV = 1666667
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          enable,
  input  logic [CW-1:0] ceil_colour,
  input  logic [CW-1:0] floor_colour,
  input  logic          slice_valid,
  input  logic [YW:0]   slice_height,
  input  logic [CW-1:0] slice_colour,
  output logic          slice_ready,
  output logic [XW-1:0] col_req,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    overrun_cnt
);

  localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_DIV - 1);
  localparam logic [XW-1:0] LAST_COL  = XW'(H_RES - 1);
  localparam logic [YW-1:0] LAST_ROW  = YW'(V_RES - 1);
  localparam logic [YW:0]   VMAX      = (YW + 1)'(V_RES);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [YW:0]   top, bot;
  logic [CW-1:0] wall;
  logic [YW:0]   h_clip;
  logic [YW:0]   top_nx;
  logic [YW:0]   row_ext;
  logic [CW-1:0] pix_colour;
  logic          xfer;

  // Free-running frame tick; deliberately ignores enable so frame pacing never drifts.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    slice_ready = 1'b0;
    col_req     = col;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) state_nx = FETCH;
      end
      FETCH: begin
        slice_ready = 1'b1;
        if (slice_valid) begin
          xfer     = 1'b1;
          state_nx = DRAW;
        end
      end
      DRAW: begin
        if (row == LAST_ROW) state_nx = (col == LAST_COL) ? DONE : FETCH;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wall geometry: clip to screen height, then centre vertically.
  always_comb begin
    h_clip  = (slice_height > VMAX) ? VMAX : slice_height;
    top_nx  = (VMAX - h_clip) >> 1;
    row_ext = {1'b0, row};
    if (row_ext < top) begin
      pix_colour = ceil_colour;
    end else if (row_ext < bot) begin
      pix_colour = wall;
    end else begin
      pix_colour = floor_colour;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col        <= '0;
      row        <= '0;
      top        <= '0;
      bot        <= '0;
      wall       <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            col  <= '0;
            busy <= 1'b1;
          end
        end
        FETCH: begin
          if (xfer) begin
            wall <= slice_colour;
            top  <= top_nx;
            bot  <= top_nx + h_clip;
            row  <= '0;
          end
        end
        DRAW: begin
          x      <= col;
          y      <= row;
          colour <= pix_colour;
          plot   <= 1'b1;
          row    <= row + 1'b1;
          if (row == LAST_ROW && col != LAST_COL) col <= col + 1'b1;
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A tick outside IDLE means the previous frame is still running: count it as dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun_cnt <= '0;
    end else if (tick && state != IDLE && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_slice_renderer.sv
// Bench for slice_renderer: random slices checked against a per-pixel geometry model.
module tb_slice_renderer;

  localparam int H  = 4;
  localparam int V  = 8;
  localparam int FD = 100;
  localparam int XW = 2;
  localparam int YW = 3;
  localparam int CW = 3;

  typedef logic [XW+YW+CW-1:0] pix_t;

  logic          clock;
  logic          resetn;
  logic          enable;
  logic [CW-1:0] ceil_c, floor_c;
  logic          slice_valid;
  logic [YW:0]   slice_height;
  logic [CW-1:0] slice_colour;
  logic          slice_ready;
  logic [XW-1:0] col_req;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot, busy, frame_done;
  logic [7:0]    overrun_cnt;

  logic [YW:0]   hv [H];
  logic [CW-1:0] wv [H];
  logic          valid_en, hold_en;
  logic [XW-1:0] hold_col;

  pix_t pix_q[$];
  pix_t exp_q[$];
  int   fd_cnt;
  int   errors;
  int   checks;

  slice_renderer #(
    .H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .CW(CW), .FRAME_DIV(FD)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .ceil_colour(ceil_c), .floor_colour(floor_c),
    .slice_valid(slice_valid), .slice_height(slice_height), .slice_colour(slice_colour),
    .slice_ready(slice_ready), .col_req(col_req),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  // Slice source answers whatever column is requested, optionally withholding one column.
  assign slice_height = hv[col_req];
  assign slice_colour = wv[col_req];
  assign slice_valid  = valid_en && !(hold_en && col_req == hold_col);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (plot === 1'b1) pix_q.push_back({x, y, colour});
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
    $fatal(1);
  end

  function automatic void build_expected();
    exp_q.delete();
    for (int c = 0; c < H; c++) begin
      int hc;
      int top;
      hc  = (int'(hv[c]) > V) ? V : int'(hv[c]);
      top = (V - hc) / 2;
      for (int r = 0; r < V; r++) begin
        logic [CW-1:0] pc;
        if (r < top) pc = ceil_c;
        else if (r < top + hc) pc = wv[c];
        else pc = floor_c;
        exp_q.push_back({XW'(c), YW'(r), pc});
      end
    end
  endfunction

  task automatic randomize_slices();
    for (int c = 0; c < H; c++) begin
      hv[c] = (YW+1)'($urandom_range(0, 15));
      wv[c] = CW'($urandom_range(0, 7));
    end
    ceil_c  = CW'($urandom_range(0, 7));
    floor_c = CW'($urandom_range(0, 7));
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic wait_frame_done(input int budget, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock);
      n++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (slice_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", slice_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
    checks++; if ({x, y, colour, col_req} !== '0) begin errors++; $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d col=%0d want 0", x, y, colour, col_req); end
    resetn = 1'b1;
  endtask

  task automatic test_fixed_frame();
    bit seen;
    int fd0;
    hv[0] = 4'd4; hv[1] = 4'd0; hv[2] = 4'd8; hv[3] = 4'd9;
    for (int c = 0; c < H; c++) wv[c] = 3'd5;
    ceil_c = 3'd1; floor_c = 3'd2;
    build_expected();
    pix_q.delete();
    fd0 = fd_cnt;
    valid_en = 1'b1;
    enable = 1'b1;
    wait_frame_done(400, seen);
    enable = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL fixed_done: frame_done not seen within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (pix_q.size() !== 32) begin errors++; $display("FAIL fixed_count: got %0d plots want 32", pix_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fixed_pix[%0d]: got {x,y,c}=%h want %h", i, pix_q[i], exp_q[i]);
      end
    end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL fixed_pulses: got %0d frame_done pulses want 1", fd_cnt - fd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy: got %b want 0 after frame", busy); end
  endtask

  task automatic test_random_frames();
    bit seen;
    for (int f = 0; f < 4; f++) begin
      randomize_slices();
      build_expected();
      pix_q.delete();
      valid_en = 1'b1;
      enable = 1'b1;
      wait_frame_done(400, seen);
      enable = 1'b0;
      checks++; if (!seen) begin errors++; $display("FAIL rand_done[%0d]: frame_done not seen", f); end
      repeat (2) @(negedge clock);
      checks++; if (pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", f, pix_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
        checks++;
        if (pix_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_pix[%0d][%0d]: got %h want %h (h=%0d)", f, i, pix_q[i], exp_q[i], hv[i / V]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit seen;
    int n;
    randomize_slices();
    build_expected();
    pix_q.delete();
    hold_col = 2'd1;
    hold_en = 1'b1;
    valid_en = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(slice_ready === 1'b1 && col_req === 2'd1) && n < 400);
    checks++; if (n >= 400) begin errors++; $display("FAIL stall_reach: col 1 fetch not reached"); end
    // First FETCH cycle still shows column 0's final registered pixel.
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (slice_ready !== 1'b1 || plot !== 1'b0 || col_req !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ready=%b plot=%b col_req=%0d want 1,0,1", i, slice_ready, plot, col_req);
      end
      @(negedge clock);
    end
    checks++; if (pix_q.size() !== V) begin errors++; $display("FAIL stall_partial: got %0d plots want %0d", pix_q.size(), V); end
    hold_en = 1'b0;
    wait_frame_done(200, seen);
    enable = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL stall_done: frame_done not seen"); end
    repeat (2) @(negedge clock);
    checks++; if (pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", pix_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_pix[%0d]: got %h want %h", i, pix_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_low();
    int bad;
    apply_reset();
    enable = 1'b0;
    valid_en = 1'b1;
    pix_q.delete();
    bad = 0;
    repeat (5 * FD + 20) begin
      @(negedge clock);
      if (busy !== 1'b0 || plot !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL enlow_activity: got %0d busy/plot cycles want 0", bad); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL enlow_overrun: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_enable_drop();
    bit seen;
    int n;
    int fd0;
    int bad;
    randomize_slices();
    build_expected();
    pix_q.delete();
    fd0 = fd_cnt;
    valid_en = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(slice_ready === 1'b1 && col_req === 2'd1) && n < 400);
    enable = 1'b0;
    checks++; if (n >= 400) begin errors++; $display("FAIL drop_reach: col 1 not reached"); end
    wait_frame_done(200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL drop_done: frame_done not seen"); end
    repeat (2) @(negedge clock);
    checks++; if (pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_count: got %0d want %0d", pix_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_pix[%0d]: got %h want %h", i, pix_q[i], exp_q[i]); end
    end
    pix_q.delete();
    bad = 0;
    repeat (3 * FD) begin
      @(negedge clock);
      if (busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || pix_q.size() !== 0) begin errors++; $display("FAIL drop_restart: got busy cycles=%0d plots=%0d want 0,0", bad, pix_q.size()); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid_draw();
    bit seen;
    int n;
    randomize_slices();
    build_expected();
    valid_en = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(plot === 1'b1 && x === 2'd2) && n < 400);
    checks++; if (n >= 400) begin errors++; $display("FAIL rst_reach: col 2 drawing not reached"); end
    resetn = 1'b0;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got plot=%b busy=%b want 0,0", plot, busy); end
    checks++; if (col_req !== 2'd0 || slice_ready !== 1'b0) begin errors++; $display("FAIL rst_col: got col_req=%0d ready=%b want 0,0", col_req, slice_ready); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    pix_q.delete();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (slice_ready !== 1'b1 && n < 400);
    checks++; if (n >= 400 || col_req !== 2'd0) begin errors++; $display("FAIL rst_restart: got col_req=%0d after %0d cycles want 0", col_req, n); end
    wait_frame_done(200, seen);
    enable = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL rst_done: frame_done not seen"); end
    repeat (2) @(negedge clock);
    checks++; if (pix_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_count: got %0d want %0d", pix_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_pix[%0d]: got %h want %h", i, pix_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    int n;
    apply_reset();
    valid_en = 1'b0;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy !== 1'b1 && n < 400);
    checks++; if (n >= 400) begin errors++; $display("FAIL ovr_start: frame did not start"); end
    // Frame is stuck in FETCH; every later tick is dropped.
    repeat (3 * FD + 50) @(negedge clock);
    checks++; if (overrun_cnt !== 8'd3) begin errors++; $display("FAIL ovr_three: got %0d want 3", overrun_cnt); end
    repeat (300 * FD) @(negedge clock);
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL ovr_saturate: got %0d want 255", overrun_cnt); end
    enable = 1'b0;
    apply_reset();
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL ovr_reset: got %0d want 0", overrun_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fd_cnt = 0;
    resetn = 1'b0;
    enable = 1'b0;
    valid_en = 1'b0;
    hold_en = 1'b0;
    hold_col = '0;
    ceil_c = '0;
    floor_c = '0;
    for (int c = 0; c < H; c++) begin
      hv[c] = '0;
      wv[c] = '0;
    end
    test_reset();
    test_fixed_frame();
    test_random_frames();
    test_stall();
    test_enable_low();
    test_enable_drop();
    test_reset_mid_draw();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
